seven_seg_scanner: RTL and testbench

// - Downstream consumer of the button-stepper's 3-bit address; drives a 4-digit,

---
 rtl/seven_seg_scanner.sv | 130 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Four-digit, common-anode, time-multiplexed 7-segment scanner.
// It shows a 4-character window of a fixed 16-character message, with blanking dead-time before each digit.
module seven_seg_scanner #(
  parameter int          REFRESH_DIV  = 50000,
  parameter int          BLANK_CYCLES = 500,
  parameter logic [63:0] MESSAGE      = 64'h0123456789ABCDEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] address,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_e;

  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [2:0]    addr_q,  addr_d;
  logic [3:0]    an_q,    an_d;
  logic [6:0]    seg_q,   seg_d;
  logic          fs_q,    fs_d;

  logic          in_blank;
  phase_e        phase;
  logic [3:0]    char_idx;
  logic [3:0]    char_code;

  function automatic logic [6:0] decode_hex(input logic [3:0] code);
    logic [6:0] glyph;
    case (code)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
    return glyph;
  endfunction

  // Character 0 is the most significant nibble of MESSAGE.
  function automatic logic [3:0] char_at(input logic [3:0] k);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      if (k == 4'(i)) c = MESSAGE[63 - 4*i -: 4];
    end
    return c;
  endfunction

  // A zero-length dead-time must not produce a compare against zero on an unsigned counter.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt_q < CW'(BLANK_CYCLES));
    end
  endgenerate

  assign phase     = in_blank ? PH_BLANK : PH_DRIVE;
  assign char_idx  = {addr_q, 1'b0} + {2'b00, digit_q};
  assign char_code = char_at(char_idx);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    cnt_d   = cnt_q + CW'(1);
    digit_d = digit_q;
    addr_d  = addr_q;
    an_d    = 4'hF;
    seg_d   = 7'h7F;
    fs_d    = (cnt_q == '0) && (digit_q == 2'd0);

    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
      // The window changes only at the end of a frame, so a frame never mixes two windows.
      if (digit_q == 2'd3) addr_d = address;
    end

    if (phase == PH_DRIVE) begin
      an_d  = ~(4'b1000 >> digit_q);
      seg_d = decode_hex(char_code);
    end
  end

  // NOTE: all state and output registers have an asynchronous reset, so the display blanks the moment reset rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      digit_q <= 2'd0;
      addr_q  <= 3'd0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      fs_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      addr_q  <= addr_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fs_q    <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = 1'b1;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: stimulus queues expected windows; a negedge monitor checks every frame.
// A second instance with no dead-time runs alongside and is checked continuously.
module tb_seven_seg_scanner;

  typedef logic [3:0][6:0] win_t;  // [slot] = expected seg while that digit is driven

  localparam win_t W0 = {7'h30, 7'h24, 7'h79, 7'h40};  // 0 1 2 3
  localparam win_t W3 = {7'h10, 7'h00, 7'h78, 7'h02};  // 6 7 8 9
  localparam win_t W5 = {7'h21, 7'h46, 7'h03, 7'h08};  // A b C d
  localparam win_t W7 = {7'h79, 7'h40, 7'h0E, 7'h06};  // E F 0 1
  localparam logic [3:0][3:0] AN_SLOT = {4'hE, 4'hD, 4'hB, 4'h7};

  logic       clock;
  logic       reset;
  logic [2:0] address;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  logic [2:0] nb_address;
  logic [3:0] nb_an;
  logic [6:0] nb_seg;
  logic       nb_dp;
  logic       nb_frame_start;

  win_t exp_q[$];
  win_t cur;
  int   n_checks    = 0;
  int   n_pass      = 0;
  int   frames_done = 0;
  int   pos         = -1;
  int   nb_pos      = -1;

  seven_seg_scanner #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  seven_seg_scanner #(.REFRESH_DIV(8), .BLANK_CYCLES(0)) u_nb (
    .clock       (clock),
    .reset       (reset),
    .address     (nb_address),
    .an          (nb_an),
    .seg         (nb_seg),
    .dp          (nb_dp),
    .frame_start (nb_frame_start)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      step(1);
      n++;
    end
    check("frames_done", frames_done, target);
  endtask

  // Monitor: a frame_start pulse opens the next expected window; each of its 32 output cycles is compared.
  initial begin
    int slot;
    int c;
    forever begin
      @(negedge clock);
      check("an_legal", int'(an inside {4'hF, 4'h7, 4'hB, 4'hD, 4'hE}), 1);
      check("nb_an_legal", int'(nb_an inside {4'hF, 4'h7, 4'hB, 4'hD, 4'hE}), 1);
      check("dp_off", dp, 1);
      check("nb_dp_off", nb_dp, 1);
      if (reset) begin
        pos    = -1;
        nb_pos = -1;
      end else begin
        if (frame_start && pos < 0 && exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          pos = 0;
        end
        if (pos >= 0) begin
          slot = pos / 8;
          c    = pos % 8;
          check("main_an",  an,  (c < 2) ? 4'hF  : AN_SLOT[slot]);
          check("main_seg", seg, (c < 2) ? 7'h7F : cur[slot]);
          check("main_frame_start", frame_start, int'(pos == 0));
          pos++;
          if (pos == 32) begin
            pos = -1;
            frames_done++;
          end
        end
        if (nb_frame_start) nb_pos = 0;
        if (nb_pos >= 0) begin
          slot = nb_pos / 8;
          check("nb_an",  nb_an,  AN_SLOT[slot]);
          check("nb_seg", nb_seg, W0[slot]);
          check("nb_frame_start", nb_frame_start, int'(nb_pos == 0));
          nb_pos = (nb_pos + 1) % 32;
        end
      end
    end
  end

  // Stimulus: inputs change 2 time units after a rising edge, clear of both clock edges.
  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    nb_address = 3'd0;
    step(3);
    check("rst_an",  an,  4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_fs",  frame_start, 0);
    check("rst_nb_an", nb_an, 4'hF);

    exp_q.push_back(W0);
    reset = 1'b0;

    step(12);                       // slot d=1 of the first frame
    address = 3'd3;
    exp_q.push_back(W3);

    step(33);                       // inside the second frame
    address = 3'd7;
    exp_q.push_back(W7);

    step(73);                       // drive phase of d=2 in the fourth frame
    check("pre_reset_an", an, 4'hD);
    check("frames_before_reset", frames_done, 3);
    reset = 1'b1;
    #1;
    check("async_rst_an",  an,  4'hF);
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_fs",  frame_start, 0);

    address = 3'd5;
    exp_q.push_back(W0);
    exp_q.push_back(W5);
    step(2);
    reset = 1'b0;

    wait_frames(5, 100);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
